// File: rtl/param_stack.sv
// Parametrised data stack for the stack CPU: T/N visible combinationally, 3-bit stack-op port,
// occupancy count and sticky overflow/underflow flags.
module param_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [CW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OpNop     = 3'd0,
    OpPush    = 3'd1,
    OpPop     = 3'd2,
    OpReplace = 3'd3,
    OpDup     = 3'd4,
    OpSwap    = 3'd5,
    OpOver    = 3'd6,
    OpBinop   = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0]    idx_t, idx_n, idx_w;
  logic [WIDTH-1:0] top, nxt;
  logic [1:0]       req;
  logic             need_space;
  logic             full;
  logic             unf_err, ovf_err;

  // Two write ports so SWAP can exchange T and N in one edge.
  logic             we_a, we_b;
  logic [AW-1:0]    idx_a, idx_b;
  logic [WIDTH-1:0] data_a, data_b;

  assign idx_t = AW'(depth_q - CW'(1));
  assign idx_n = AW'(depth_q - CW'(2));
  assign idx_w = depth_q[AW-1:0];
  assign full  = (depth_q == CW'(DEPTH));

  // Stale array contents stay hidden behind the depth gating.
  assign top = (depth_q != '0)      ? mem[idx_t] : '0;
  assign nxt = (depth_q >= CW'(2))  ? mem[idx_n] : '0;

  always_comb begin
    req        = 2'd0;
    need_space = 1'b0;
    unique case (op_e'(i_op))
      OpNop:     begin req = 2'd0; need_space = 1'b0; end
      OpPush:    begin req = 2'd0; need_space = 1'b1; end
      OpPop:     begin req = 2'd1; need_space = 1'b0; end
      OpReplace: begin req = 2'd1; need_space = 1'b0; end
      OpDup:     begin req = 2'd1; need_space = 1'b1; end
      OpSwap:    begin req = 2'd2; need_space = 1'b0; end
      OpOver:    begin req = 2'd2; need_space = 1'b1; end
      OpBinop:   begin req = 2'd2; need_space = 1'b0; end
      default:   begin req = 2'd0; need_space = 1'b0; end
    endcase
  end

  assign unf_err = (depth_q < CW'(req));
  assign ovf_err = !unf_err && need_space && full;

  always_comb begin
    depth_d = depth_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    idx_a   = idx_w;
    idx_b   = idx_n;
    data_a  = i_data;
    data_b  = top;
    if (!unf_err && !ovf_err) begin
      unique case (op_e'(i_op))
        OpNop: ;
        OpPush: begin
          we_a    = 1'b1;
          depth_d = depth_q + CW'(1);
        end
        OpPop: depth_d = depth_q - CW'(1);
        OpReplace: begin
          we_a  = 1'b1;
          idx_a = idx_t;
        end
        OpDup: begin
          we_a    = 1'b1;
          data_a  = top;
          depth_d = depth_q + CW'(1);
        end
        OpSwap: begin
          we_a   = 1'b1;
          idx_a  = idx_t;
          data_a = nxt;
          we_b   = 1'b1;
        end
        OpOver: begin
          we_a    = 1'b1;
          data_a  = nxt;
          depth_d = depth_q + CW'(1);
        end
        OpBinop: begin
          we_a    = 1'b1;
          idx_a   = idx_n;
          depth_d = depth_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // A fresh error wins over a simultaneous clear.
  assign ovf_d = ovf_err ? 1'b1 : (i_clear_err ? 1'b0 : ovf_q);
  assign unf_d = unf_err ? 1'b1 : (i_clear_err ? 1'b0 : unf_q);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (we_a) mem[idx_a] <= data_a;
    if (we_b) mem[idx_b] <= data_b;
  end

  assign o_top       = top;
  assign o_next      = nxt;
  assign o_depth     = depth_q;
  assign o_empty     = (depth_q == '0);
  assign o_full      = full;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule
